// File: rtl/fetch_unit.sv
// Instruction fetch unit: fetches one word, holds it for decode/execute, then
// updates the fetch address register before the next fetch.
module fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        de_addreg_update,
  input  logic [1:0]  de_addreg_sel,
  input  logic [31:0] alu_result,
  input  logic [31:0] reg_pc_value,
  input  logic        ex_done,
  input  logic        mem_rd_ack,
  input  logic [31:0] mem_rd_data,
  output logic        mem_rd_req,
  output logic [31:0] mem_addr,
  output logic [31:0] fd_instruction,
  output logic        fd_valid,
  output logic [31:0] fd_pc
);

  localparam logic [31:0] Nop = 32'hE1A0_0000;

  typedef enum logic [1:0] {
    StFetch  = 2'd0,
    StHold   = 2'd1,
    StUpdate = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] addreg_q, addreg_d;
  logic [31:0] fd_instr_q, fd_instr_d;
  logic [31:0] fd_pc_q, fd_pc_d;
  logic        fd_valid_q, fd_valid_d;
  logic [31:0] addr_src;

  // Select the candidate next fetch address; INC and the reserved code both step by one word.
  always_comb begin
    addr_src = addreg_q + 32'd4;
    case (de_addreg_sel)
      2'b00:   addr_src = alu_result;
      2'b01:   addr_src = reg_pc_value;
      default: addr_src = addreg_q + 32'd4;
    endcase
  end

  // Next-state and captured-instruction logic for the FETCH/HOLD/UPDATE sequence.
  always_comb begin
    state_d    = state_q;
    addreg_d   = addreg_q;
    fd_instr_d = fd_instr_q;
    fd_pc_d    = fd_pc_q;
    fd_valid_d = fd_valid_q;
    unique case (state_q)
      StFetch: begin
        if (mem_rd_ack) begin
          fd_instr_d = mem_rd_data;
          fd_pc_d    = addreg_q;
          fd_valid_d = 1'b1;
          state_d    = StHold;
        end
      end
      StHold: begin
        if (ex_done) begin
          fd_valid_d = 1'b0;
          state_d    = StUpdate;
        end
      end
      StUpdate: begin
        // Without an update request the same address is refetched.
        if (de_addreg_update) begin
          addreg_d = {addr_src[31:2], 2'b00};
        end
        state_d = StFetch;
      end
      default: state_d = StFetch;
    endcase
  end

  // State registers with synchronous reset; reset also discards any concurrent ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StFetch;
      addreg_q   <= {RESET_VECTOR[31:2], 2'b00};
      fd_instr_q <= Nop;
      fd_pc_q    <= 32'h0;
      fd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addreg_q   <= addreg_d;
      fd_instr_q <= fd_instr_d;
      fd_pc_q    <= fd_pc_d;
      fd_valid_q <= fd_valid_d;
    end
  end

  // Request is gated by reset so it stays low for the whole reset period.
  always_comb begin
    mem_rd_req = (state_q == StFetch) && !rst;
  end

  assign mem_addr       = addreg_q;
  assign fd_instruction = fd_instr_q;
  assign fd_pc          = fd_pc_q;
  assign fd_valid       = fd_valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit.
module tb_fetch_unit;

  localparam logic [31:0] Nop = 32'hE1A0_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        de_addreg_update;
  logic [1:0]  de_addreg_sel;
  logic [31:0] alu_result;
  logic [31:0] reg_pc_value;
  logic        ex_done;
  logic        mem_rd_ack;
  logic [31:0] mem_rd_data;
  logic        mem_rd_req;
  logic [31:0] mem_addr;
  logic [31:0] fd_instruction;
  logic        fd_valid;
  logic [31:0] fd_pc;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // Low bits of the reset vector must be dropped, so the first fetch is still at 0.
  fetch_unit #(
    .RESET_VECTOR(32'h0000_0003)
  ) u_dut (
    .clk             (clk),
    .rst             (rst),
    .de_addreg_update(de_addreg_update),
    .de_addreg_sel   (de_addreg_sel),
    .alu_result      (alu_result),
    .reg_pc_value    (reg_pc_value),
    .ex_done         (ex_done),
    .mem_rd_ack      (mem_rd_ack),
    .mem_rd_data     (mem_rd_data),
    .mem_rd_req      (mem_rd_req),
    .mem_addr        (mem_addr),
    .fd_instruction  (fd_instruction),
    .fd_valid        (fd_valid),
    .fd_pc           (fd_pc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock edge and settle past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one ack with data in the current FETCH cycle.
  task automatic do_fetch(input logic [31:0] data);
    mem_rd_ack  = 1'b1;
    mem_rd_data = data;
    tick();
    mem_rd_ack  = 1'b0;
    mem_rd_data = 32'h0;
  endtask

  // Retire the held instruction: ex_done in HOLD, then the UPDATE cycle.
  task automatic retire(input logic upd, input logic [1:0] sel, input logic [31:0] alu,
                        input logic [31:0] pcv);
    de_addreg_update = upd;
    de_addreg_sel    = sel;
    alu_result       = alu;
    reg_pc_value     = pcv;
    ex_done          = 1'b1;
    tick();
    ex_done = 1'b0;
    check("upd_valid_low", {31'h0, fd_valid}, 32'h0);
    check("upd_req_low", {31'h0, mem_rd_req}, 32'h0);
    tick();
    de_addreg_update = 1'b0;
    de_addreg_sel    = 2'b00;
    alu_result       = 32'h0;
    reg_pc_value     = 32'h0;
  endtask

  initial begin
    rst              = 1'b1;
    de_addreg_update = 1'b0;
    de_addreg_sel    = 2'b00;
    alu_result       = 32'h0;
    reg_pc_value     = 32'h0;
    ex_done          = 1'b0;
    // Ack during reset must be discarded.
    mem_rd_ack       = 1'b1;
    mem_rd_data      = 32'hDEAD_BEEF;
    tick();
    tick();
    check("rst_req", {31'h0, mem_rd_req}, 32'h0);
    check("rst_valid", {31'h0, fd_valid}, 32'h0);
    check("rst_instr", fd_instruction, Nop);
    check("rst_pc", fd_pc, 32'h0);
    check("rst_addr", mem_addr, 32'h0);

    rst        = 1'b0;
    mem_rd_ack = 1'b0;
    // ex_done is asserted during the stall and must be ignored in FETCH.
    ex_done    = 1'b1;
    #1;
    check("first_req", {31'h0, mem_rd_req}, 32'h1);

    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_req", {31'h0, mem_rd_req}, 32'h1);
      check("stall_addr", mem_addr, 32'h0);
      check("stall_valid", {31'h0, fd_valid}, 32'h0);
      check("stall_instr", fd_instruction, Nop);
    end
    ex_done = 1'b0;

    do_fetch(32'hE3A0_1005);
    check("f0_valid", {31'h0, fd_valid}, 32'h1);
    check("f0_instr", fd_instruction, 32'hE3A0_1005);
    check("f0_pc", fd_pc, 32'h0);
    check("hold_req", {31'h0, mem_rd_req}, 32'h0);

    // Ack and update inputs in HOLD must be ignored.
    mem_rd_ack       = 1'b1;
    mem_rd_data      = 32'h1111_1111;
    de_addreg_update = 1'b1;
    alu_result       = 32'h0000_0800;
    tick();
    tick();
    mem_rd_ack       = 1'b0;
    de_addreg_update = 1'b0;
    check("hold_instr", fd_instruction, 32'hE3A0_1005);
    check("hold_valid", {31'h0, fd_valid}, 32'h1);
    check("hold_addr", mem_addr, 32'h0);

    // Branch via ALU with low bits set: lands on 0x100.
    retire(1'b1, 2'b00, 32'h0000_0101, 32'h0);
    check("br100_req", {31'h0, mem_rd_req}, 32'h1);
    check("br100_addr", mem_addr, 32'h0000_0100);
    check("br100_instr_kept", fd_instruction, 32'hE3A0_1005);

    do_fetch(32'hAAAA_0001);
    check("f1_pc", fd_pc, 32'h0000_0100);
    check("f1_instr", fd_instruction, 32'hAAAA_0001);
    retire(1'b1, 2'b10, 32'h0, 32'h0);
    check("inc_req", {31'h0, mem_rd_req}, 32'h1);
    check("inc_addr", mem_addr, 32'h0000_0104);

    do_fetch(32'hAAAA_0002);
    check("f2_pc", fd_pc, 32'h0000_0104);
    retire(1'b1, 2'b00, 32'h0000_0203, 32'h0);
    check("alu_addr", mem_addr, 32'h0000_0200);

    do_fetch(32'hAAAA_0003);
    retire(1'b0, 2'b00, 32'h0000_0500, 32'h0);
    check("refetch_addr", mem_addr, 32'h0000_0200);
    check("refetch_req", {31'h0, mem_rd_req}, 32'h1);

    do_fetch(32'hAAAA_0004);
    check("f4_pc", fd_pc, 32'h0000_0200);
    retire(1'b1, 2'b01, 32'h0, 32'hFFFF_FFFE);
    check("pc_addr", mem_addr, 32'hFFFF_FFFC);

    do_fetch(32'hAAAA_0005);
    check("f5_pc", fd_pc, 32'hFFFF_FFFC);
    retire(1'b1, 2'b11, 32'h0, 32'h0);
    check("wrap_addr", mem_addr, 32'h0);

    do_fetch(32'hAAAA_0006);
    retire(1'b1, 2'b00, 32'h0000_0344, 32'h0);
    check("pre_rst_addr", mem_addr, 32'h0000_0344);

    // Stall, then reset mid-fetch with a late ack.
    tick();
    tick();
    rst = 1'b1;
    #1;
    check("rst_mid_req", {31'h0, mem_rd_req}, 32'h0);
    mem_rd_ack  = 1'b1;
    mem_rd_data = 32'hBAD0_BAD0;
    tick();
    check("rst_mid_instr", fd_instruction, Nop);
    check("rst_mid_valid", {31'h0, fd_valid}, 32'h0);
    check("rst_mid_pc", fd_pc, 32'h0);
    check("rst_mid_addr", mem_addr, 32'h0);
    rst        = 1'b0;
    mem_rd_ack = 1'b0;
    #1;
    check("post_rst_req", {31'h0, mem_rd_req}, 32'h1);
    tick();
    check("post_rst_valid", {31'h0, fd_valid}, 32'h0);
    check("post_rst_instr", fd_instruction, Nop);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
